// File: rtl/demux_1_9_collect_pkg.sv
// demux_1_9_collect_pkg: shared widths and FSM state encoding for the 1:9 word collector
package demux_1_9_collect_pkg;
  localparam int DATA_W  = 16;
  localparam int N_WORDS = 9;
  localparam int SEL_W   = 4;
  localparam logic ST_COLLECT = 1'b0;
  localparam logic ST_HOLD    = 1'b1;
  typedef enum logic {COLLECT = ST_COLLECT, HOLD = ST_HOLD} state_e;
endpackage

// File: rtl/demux_1_9_collect_if.sv
// demux_1_9_collect_if: stream-in / frame-out handshake bundle (master = producer+consumer side, slave = collector)
interface demux_1_9_collect_if;
  import demux_1_9_collect_pkg::*;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [DATA_W-1:0] out_1, out_2, out_3, out_4, out_5, out_6, out_7, out_8, out_9;
  logic              out_valid;
  logic              out_ready;
  logic [SEL_W-1:0]  sel_idx;
  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_1, out_2, out_3, out_4, out_5, out_6, out_7, out_8, out_9, out_valid, sel_idx
  );
  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_1, out_2, out_3, out_4, out_5, out_6, out_7, out_8, out_9, out_valid, sel_idx
  );
endinterface

// File: rtl/demux_1_9_collect_idx_counter_mod9.sv
// idx_counter_mod9: write-index counter 0..N_WORDS-1 with enable, sync clear and last-word flag; ports clk, rst, i_en, i_clr, o_idx, o_last
module idx_counter_mod9
  import demux_1_9_collect_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_last
);
  logic [SEL_W-1:0] r_idx;
  // out-of-range values behave as the last index so the counter always recovers to 0
  assign o_last = r_idx >= SEL_W'(N_WORDS - 1);
  assign o_idx  = r_idx;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_idx <= '0;
    else r_idx <= i_clr ? '0 : i_en ? (o_last ? '0 : r_idx + 1'b1) : r_idx;
endmodule

// File: rtl/demux_1_9_collect.sv
// demux_1_9_collect: gathers 9 serial DATA_W words into parallel registers and offers them as one frame; ports clk, rst, s (slave handshake bundle)
module demux_1_9_collect
  import demux_1_9_collect_pkg::*;
(
  input logic clk,
  input logic rst,
  demux_1_9_collect_if.slave s
);
  state_e            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_data [N_WORDS];
  logic [SEL_W-1:0]  w_idx;
  logic              w_last, w_wr;
  // flush drops a word arriving in the same cycle
  assign w_wr = s.in_valid && s.in_ready && !s.flush;
  idx_counter_mod9 u_idx (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_wr),
    .i_clr  (s.flush),
    .o_idx  (w_idx),
    .o_last (w_last)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= COLLECT;
    else r_state <= w_state_nxt;
  always_comb begin
    w_state_nxt = r_state;
    if (s.flush) w_state_nxt = COLLECT;
    else if (r_state == COLLECT && w_wr && w_last) w_state_nxt = HOLD;
    else if (r_state == HOLD && s.out_ready) w_state_nxt = COLLECT;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int k = 0; k < N_WORDS; k++) r_data[k] <= '0;
    else
      for (int k = 0; k < N_WORDS; k++)
        if (w_wr && (w_idx == SEL_W'(k) || (k == N_WORDS - 1 && w_idx > SEL_W'(k)))) r_data[k] <= s.in_data;
  // in_ready is masked during reset since the state register already reads COLLECT
  assign s.in_ready  = !rst && r_state == COLLECT;
  assign s.out_valid = r_state == HOLD;
  assign s.sel_idx   = w_idx;
  assign s.out_1 = r_data[0];
  assign s.out_2 = r_data[1];
  assign s.out_3 = r_data[2];
  assign s.out_4 = r_data[3];
  assign s.out_5 = r_data[4];
  assign s.out_6 = r_data[5];
  assign s.out_7 = r_data[6];
  assign s.out_8 = r_data[7];
  assign s.out_9 = r_data[8];
endmodule

// File: tb/tb_demux_1_9_collect.sv
// tb_demux_1_9_collect: directed self-checking bench for the 1:9 word collector
module tb_demux_1_9_collect;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  demux_1_9_collect_if bus ();
  demux_1_9_collect dut (.clk(clk), .rst(rst), .s(bus.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] outk(input int k);
    case (k)
      1: return bus.out_1;
      2: return bus.out_2;
      3: return bus.out_3;
      4: return bus.out_4;
      5: return bus.out_5;
      6: return bus.out_6;
      7: return bus.out_7;
      8: return bus.out_8;
      default: return bus.out_9;
    endcase
  endfunction
  initial begin
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("post_reset_in_ready", 16'(bus.in_ready), 16'h1);
    check("post_reset_sel", 16'(bus.sel_idx), 16'h0);
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.in_data = 16'h1110 + 16'(i);
      tick();
    end
    check("pre_rst_sel", 16'(bus.sel_idx), 16'h4);
    check("pre_rst_out1", bus.out_1, 16'h1111);
    #2 rst = 1'b1;
    #1;
    for (int k = 1; k <= 9; k++) check($sformatf("rst_out%0d", k), outk(k), 16'h0);
    check("rst_out_valid", 16'(bus.out_valid), 16'h0);
    check("rst_sel", 16'(bus.sel_idx), 16'h0);
    check("rst_in_ready", 16'(bus.in_ready), 16'h0);
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("rel_in_ready", 16'(bus.in_ready), 16'h1);
    tick();
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      bus.in_data = 16'(i);
      tick();
      if (i < 9) check($sformatf("b2b_valid_%0d", i), 16'(bus.out_valid), 16'h0);
    end
    bus.in_valid = 1'b0;
    check("b2b_out_valid", 16'(bus.out_valid), 16'h1);
    check("b2b_in_ready", 16'(bus.in_ready), 16'h0);
    check("b2b_sel", 16'(bus.sel_idx), 16'h0);
    for (int k = 1; k <= 9; k++) check($sformatf("b2b_out%0d", k), outk(k), 16'(k));
    tick();
    check("b2b_rel_valid", 16'(bus.out_valid), 16'h0);
    check("b2b_rel_in_ready", 16'(bus.in_ready), 16'h1);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.in_data = 16'hA000 + 16'(i);
      tick();
    end
    bus.in_data = 16'hDEAD;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_valid_%0d", c), 16'(bus.out_valid), 16'h1);
      check($sformatf("bp_in_ready_%0d", c), 16'(bus.in_ready), 16'h0);
      check($sformatf("bp_sel_%0d", c), 16'(bus.sel_idx), 16'h0);
      check($sformatf("bp_out1_%0d", c), bus.out_1, 16'hA000);
      check($sformatf("bp_out9_%0d", c), bus.out_9, 16'hA008);
      tick();
    end
    check("bp_out5", bus.out_5, 16'hA004);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("bp_rel_valid", 16'(bus.out_valid), 16'h0);
    check("bp_rel_in_ready", 16'(bus.in_ready), 16'h1);
    check("bp_rel_sel", 16'(bus.sel_idx), 16'h0);
    check("bp_rel_keep", bus.out_1, 16'hA000);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.in_data = (i % 2 == 0) ? 16'hC001 + 16'(i / 2) : 16'hEEEE;
      tick();
      check($sformatf("gap_sel_%0d", i), 16'(bus.sel_idx), 16'((i / 2 + 1) % 9));
    end
    bus.in_valid = 1'b0;
    check("gap_valid", 16'(bus.out_valid), 16'h1);
    for (int k = 1; k <= 9; k++) check($sformatf("gap_out%0d", k), outk(k), 16'hC000 + 16'(k));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("gap_rel_valid", 16'(bus.out_valid), 16'h0);
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.in_data = 16'hD000 + 16'(i);
      tick();
    end
    check("fl_pre_sel", 16'(bus.sel_idx), 16'h4);
    bus.flush = 1'b1;
    bus.in_data = 16'hDDDD;
    tick();
    bus.flush = 1'b0;
    check("fl_sel", 16'(bus.sel_idx), 16'h0);
    check("fl_dropped", bus.out_5, 16'hC005);
    check("fl_kept", bus.out_4, 16'hD004);
    check("fl_in_ready", 16'(bus.in_ready), 16'h1);
    for (int i = 1; i <= 9; i++) begin
      bus.in_data = 16'hB000 + 16'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    check("fl_frame_valid", 16'(bus.out_valid), 16'h1);
    for (int k = 1; k <= 9; k++) check($sformatf("fl_out%0d", k), outk(k), 16'hB000 + 16'(k));
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    check("flh_valid", 16'(bus.out_valid), 16'h0);
    check("flh_in_ready", 16'(bus.in_ready), 16'h1);
    check("flh_sel", 16'(bus.sel_idx), 16'h0);
    check("flh_out1", bus.out_1, 16'hB001);
    check("flh_out9", bus.out_9, 16'hB009);
    tick();
    check("idle_valid", 16'(bus.out_valid), 16'h0);
    check("idle_sel", 16'(bus.sel_idx), 16'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
